// File: rtl/uart_tx_scheduler_pkg.sv
// Shared constants, FSM encoding and baud-code helper for the UART TX scheduler.
package uart_tx_scheduler_pkg;

   localparam int unsigned CLK_HZ = 50_000_000;
   localparam int unsigned WD_W   = 17;

   localparam logic [1:0] BAUD_9600   = 2'b00;
   localparam logic [1:0] BAUD_57600  = 2'b01;
   localparam logic [1:0] BAUD_115200 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ACCEPT    = 2'd1,
      ST_START     = 2'd2,
      ST_WAIT_DONE = 2'd3
   } sched_state_e;

   // Reserved code 11 falls back to the slowest rate.
   function automatic logic [1:0] map_baud(input logic [1:0] sel);
      case (sel)
         BAUD_57600:  return BAUD_57600;
         BAUD_115200: return BAUD_115200;
         default:     return BAUD_9600;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr_i, wrapping.
module uart_tx_scheduler_rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  valid_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] grant_o,
   output logic          any_valid_o
);

   logic        found;
   int unsigned idx;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = (32'(ptr_i) + off) % N;
         if (!found && valid_i[IW'(idx)]) begin
            grant_o = IW'(idx);
            found   = 1'b1;
         end
      end
      any_valid_o = found;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
// Optional watchdog on the TX core enabled by UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int unsigned N_REQ       = 4,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 65536
) (
   input  logic                      src_clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [1:0]                baud_sel,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   output logic [1:0]                tx_baud_sel,
   input  logic                      tx_done,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      active,
   output logic                      timeout_err
);

   localparam int unsigned GW = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << WD_W)) begin : g_cfg_err
      $error("uart_tx_scheduler: unsupported parameter set");
   end

   sched_state_e        state_q, state_d;
   logic [GW-1:0]       ptr_q, ptr_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [1:0]          baud_q, baud_d;
   logic [N_REQ-1:0]    ready_q, ready_d;
   logic                start_q, start_d;
   logic                active_q, active_d;
   logic [GW-1:0]       arb_grant;
   logic                arb_any;
   logic [GW-1:0]       ptr_next;

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
   logic                err_q, err_d;
`endif

   uart_tx_scheduler_rr_arbiter #(.N(N_REQ), .IW(GW)) u_arb (
      .valid_i     (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (arb_grant),
      .any_valid_o (arb_any)
   );

   assign ptr_next = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);

   always_ff @(posedge src_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         grant_q  <= '0;
         data_q   <= '0;
         baud_q   <= '0;
         ready_q  <= '0;
         start_q  <= 1'b0;
         active_q <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         baud_q   <= baud_d;
         ready_q  <= ready_d;
         start_q  <= start_d;
         active_q <= active_d;
`ifdef UART_TX_SCHED_TIMEOUT_EN
         wd_cnt_q <= wd_cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   // Next-state and registered-output decode; byte and baud latch only on grant.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      data_d   = data_q;
      baud_d   = baud_q;
      ready_d  = '0;
      start_d  = 1'b0;
      active_d = active_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      wd_cnt_d = wd_cnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_d            = arb_grant;
               data_d             = req_data[32'(arb_grant)*DATA_W +: DATA_W];
               baud_d             = map_baud(baud_sel);
               ready_d[arb_grant] = 1'b1;
               active_d           = 1'b1;
               state_d            = ST_ACCEPT;
            end
         end
         ST_ACCEPT: begin
            start_d = 1'b1;
            state_d = ST_START;
         end
         ST_START: begin
            state_d = ST_WAIT_DONE;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            wd_cnt_d = '0;
`endif
         end
         ST_WAIT_DONE: begin
            if (tx_done) begin
               state_d  = ST_IDLE;
               ptr_d    = ptr_next;
               active_d = 1'b0;
            end
`ifdef UART_TX_SCHED_TIMEOUT_EN
            else if (wd_cnt_q == WD_LAST) begin
               state_d  = ST_IDLE;
               ptr_d    = ptr_next;
               active_d = 1'b0;
               err_d    = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready   = ready_q;
   assign tx_start    = start_q;
   assign tx_data     = data_q;
   assign tx_baud_sel = baud_q;
   assign grant_id    = grant_q;
   assign active      = active_q;
`ifdef UART_TX_SCHED_TIMEOUT_EN
   assign timeout_err = err_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (4 requesters, byte data).
// Watchdog checks follow UART_TX_SCHED_TIMEOUT_EN with TIMEOUT_CYC=100.
module tb_uart_tx_scheduler;

   logic        src_clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [1:0]  baud_sel;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [1:0]  tx_baud_sel;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   uart_tx_scheduler #(.N_REQ(4), .DATA_W(8), .TIMEOUT_CYC(100)) dut (
      .src_clk     (src_clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .baud_sel    (baud_sel),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_baud_sel (tx_baud_sel),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .active      (active),
      .timeout_err (timeout_err)
   );

   initial src_clk = 1'b0;
   always #5 src_clk = ~src_clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "bench time limit reached");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full frame: wait for the accept pulse, check the start pulse and latched
   // values, hold 20 cycles, then pulse tx_done. Entered and left on a negedge.
   task automatic run_frame(input string tag, input int g, input logic [7:0] d,
                            input logic [1:0] b, input bit drop, input bit mutate);
      int n = 0;
      while (req_ready === 4'b0000 && n < 20) begin
         @(negedge src_clk);
         n++;
      end
      chk({tag, "_ready"}, 32'(req_ready), 32'(1 << g));
      chk({tag, "_gid"}, 32'(grant_id), 32'(g));
      chk({tag, "_active"}, 32'(active), 32'd1);
      if (drop) req_valid = 4'b0000;
      @(negedge src_clk);
      chk({tag, "_start"}, 32'(tx_start), 32'd1);
      chk({tag, "_data"}, 32'(tx_data), 32'(d));
      chk({tag, "_baud"}, 32'(tx_baud_sel), 32'(b));
      chk({tag, "_ready_off"}, 32'(req_ready), 32'd0);
      if (mutate) begin
         baud_sel       = 2'b10;
         req_data[7:0]  = 8'h22;
      end
      repeat (20) @(negedge src_clk);
      chk({tag, "_start_off"}, 32'(tx_start), 32'd0);
      chk({tag, "_data_hold"}, 32'(tx_data), 32'(d));
      chk({tag, "_baud_hold"}, 32'(tx_baud_sel), 32'(b));
      chk({tag, "_busy"}, 32'(active), 32'd1);
      tx_done = 1'b1;
      @(negedge src_clk);
      tx_done = 1'b0;
      chk({tag, "_done"}, 32'(active), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      req_data  = 32'h0;
      baud_sel  = 2'b00;
      tx_done   = 1'b0;
      repeat (3) @(negedge src_clk);

      // Reset values
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_start", 32'(tx_start), 32'd0);
      chk("rst_data", 32'(tx_data), 32'd0);
      chk("rst_baud", 32'(tx_baud_sel), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_active", 32'(active), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      @(negedge src_clk);

      // Single byte from requester 2
      req_valid = 4'b0100;
      req_data[23:16] = 8'h52;
      @(negedge src_clk);
      chk("t1_lat_ready", 32'(req_ready), 32'h4);
      chk("t1_lat_nostart", 32'(tx_start), 32'd0);
      run_frame("t1", 2, 8'h52, 2'b00, 1'b1, 1'b0);

      // Latch stability, then next frame picks the new byte and baud; reserved baud maps to 9600
      req_valid     = 4'b0001;
      req_data[7:0] = 8'h11;
      run_frame("t3a", 0, 8'h11, 2'b00, 1'b0, 1'b1);
      run_frame("t3b", 0, 8'h22, 2'b10, 1'b0, 1'b0);
      baud_sel = 2'b11;
      run_frame("t3c", 0, 8'h22, 2'b00, 1'b1, 1'b0);

      // Spurious tx_done in IDLE and in ACCEPT
      tx_done = 1'b1;
      @(negedge src_clk);
      tx_done = 1'b0;
      chk("t4_idle_ready", 32'(req_ready), 32'd0);
      chk("t4_idle_active", 32'(active), 32'd0);
      chk("t4_idle_start", 32'(tx_start), 32'd0);
      req_valid       = 4'b0010;
      req_data[15:8]  = 8'h77;
      @(negedge src_clk);
      chk("t4_acc_ready", 32'(req_ready), 32'h2);
      req_valid = 4'b0000;
      tx_done   = 1'b1;
      @(negedge src_clk);
      tx_done = 1'b0;
      chk("t4_start", 32'(tx_start), 32'd1);
      chk("t4_data", 32'(tx_data), 32'h77);
      chk("t4_noready", 32'(req_ready), 32'd0);
      repeat (3) @(negedge src_clk);
      chk("t4_still_busy", 32'(active), 32'd1);
      tx_done = 1'b1;
      @(negedge src_clk);
      tx_done = 1'b0;
      chk("t4_done", 32'(active), 32'd0);
      @(negedge src_clk);
      chk("t4_no_extra", 32'(req_ready), 32'd0);

      // Contention from a fresh pointer
      rst_n = 1'b0;
      @(negedge src_clk);
      rst_n     = 1'b1;
      req_data  = 32'h44434241;
      baud_sel  = 2'b01;
      req_valid = 4'b1111;
      for (int f = 0; f < 5; f++) begin
         run_frame("t2", f % 4, 8'(8'h41 + f % 4), 2'b01, 1'b0, 1'b0);
      end

      // Reset mid-frame while requester 1 is being served
      @(negedge src_clk);
      chk("t5_gid1", 32'(grant_id), 32'd1);
      @(negedge src_clk);
      @(negedge src_clk);
      chk("t5_busy", 32'(active), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_active", 32'(active), 32'd0);
      chk("t5_rst_start", 32'(tx_start), 32'd0);
      chk("t5_rst_ready", 32'(req_ready), 32'd0);
      @(negedge src_clk);
      rst_n = 1'b1;
      run_frame("t5", 0, 8'h41, 2'b01, 1'b0, 1'b0);

      // Watchdog on a TX core that never answers
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      @(negedge src_clk);
      rst_n     = 1'b1;
      req_valid = 4'b0011;
      @(negedge src_clk);
      chk("t6_ready0", 32'(req_ready), 32'h1);
      @(negedge src_clk);
      chk("t6_start", 32'(tx_start), 32'd1);
      req_valid = 4'b0010;
      repeat (100) @(negedge src_clk);
      chk("t6_pre_err", 32'(timeout_err), 32'd0);
      chk("t6_pre_active", 32'(active), 32'd1);
      @(negedge src_clk);
`ifdef UART_TX_SCHED_TIMEOUT_EN
      chk("t6_err", 32'(timeout_err), 32'd1);
      chk("t6_idle", 32'(active), 32'd0);
      @(negedge src_clk);
      chk("t6_next_ready", 32'(req_ready), 32'h2);
      chk("t6_next_gid", 32'(grant_id), 32'd1);
      req_valid = 4'b0000;
      @(negedge src_clk);
      chk("t6_next_data", 32'(tx_data), 32'h42);
      repeat (3) @(negedge src_clk);
      tx_done = 1'b1;
      @(negedge src_clk);
      tx_done = 1'b0;
      chk("t6_sticky", 32'(timeout_err), 32'd1);
      chk("t6_done", 32'(active), 32'd0);
`else
      chk("t6_noerr", 32'(timeout_err), 32'd0);
      chk("t6_waiting", 32'(active), 32'd1);
      repeat (5) @(negedge src_clk);
      chk("t6_no_grant", 32'(req_ready), 32'd0);
      tx_done = 1'b1;
      @(negedge src_clk);
      tx_done = 1'b0;
      run_frame("t6n", 1, 8'h42, 2'b01, 1'b1, 1'b0);
      chk("t6_noerr_end", 32'(timeout_err), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
